// File: rtl/sigmoid_arbiter_pkg.sv
// sigmoid_arbiter_pkg
//   Shared definitions for the sigmoid arbiter and its round-robin helper:
//   FSM state encoding, default geometry and the float zero constant.
//   No ports (package).
package sigmoid_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam int DEF_S       = 32;
    localparam int DEF_N       = 2;
    localparam int DEF_R       = 4;
    localparam int DEF_TIMEOUT = 256;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/sigmoid_arbiter_rr.sv
// rr_arbiter
//   Purely combinational round-robin pick. Scans ptr+1, ptr+2, ... modulo R
//   and returns the first requester found, so the requester at ptr has the
//   lowest priority. Reusable by any shared NN unit.
// Ports
//   req     in   R          request vector
//   ptr     in   clog2(R)   last-served requester
//   winner  out  R          one-hot winner (zero when nobody requests)
//   any     out  1          at least one request present
module rr_arbiter #(
    parameter int R = 4
) (
    input  logic [R-1:0]         req,
    input  logic [$clog2(R)-1:0] ptr,
    output logic [R-1:0]         winner,
    output logic                 any
);

    always_comb begin
        int idx;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int i = 1; i <= R; i++) begin
            idx = (int'(ptr) + i) % R;
            if (!any && req[idx]) begin
                winner[idx] = 1'b1;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter
//   Shares one sigmoid unit (S-bit floats, N lanes) between R requesters.
//   Round-robin grant, operand latched, unit cleared+started, then the rising
//   edge of sig_done is awaited and the result returned to the owner.
//   All outputs are registered.
// Optional feature
//   SIGMOID_ARB_TIMEOUT_EN : watchdog in WAIT; after TIMEOUT cycles without a
//   done edge the job is aborted (err + rsp_valid with zero result, unit
//   cleared for one cycle). Without it there is no err port.
// Ports
//   clk, rst_n         clock / async active-low reset
//   req[R]             level request, held until gnt
//   req_x[R*S*N]       operands, slice r = req_x[r*S*N +: S*N]
//   gnt[R]             one-hot pulse, operand latched
//   rsp_valid[R]       one-hot pulse, rsp_y belongs to that requester
//   rsp_y[S*N]         result, held until next response
//   busy               high from grant through response cycle
//   sig_clr_n          to sigmoid rst_n (low = clear)
//   sig_start          to sigmoid start
//   sig_x[S*N]         to sigmoid x, stable for the whole job
//   sig_y[S*N]         from sigmoid y
//   sig_done           from sigmoid done (level)
//   err                abort pulse (SIGMOID_ARB_TIMEOUT_EN only)
module sigmoid_arbiter
    import sigmoid_arbiter_pkg::*;
#(
    parameter int S       = DEF_S,
    parameter int N       = DEF_N,
    parameter int R       = DEF_R,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [R-1:0]     req,
    input  logic [R*S*N-1:0] req_x,
    output logic [R-1:0]     gnt,
    output logic [R-1:0]     rsp_valid,
    output logic [S*N-1:0]   rsp_y,
    output logic             busy,
    output logic             sig_clr_n,
    output logic             sig_start,
    output logic [S*N-1:0]   sig_x,
    input  logic [S*N-1:0]   sig_y,
    input  logic             sig_done
`ifdef SIGMOID_ARB_TIMEOUT_EN
    ,
    output logic             err
`endif
);

    localparam int W  = S * N;
    localparam int PW = $clog2(R);

    if (R < 2) begin : g_r_check
        $error("sigmoid_arbiter: R must be >= 2");
    end
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("sigmoid_arbiter: TIMEOUT must be >= 1");
    end

    arb_state_e     state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [R-1:0]   gnt_q, gnt_d;
    logic [R-1:0]   rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_y_q, rsp_y_d;
    logic           busy_q, busy_d;
    logic           clr_n_q, clr_n_d;
    logic           start_q, start_d;
    logic [W-1:0]   sig_x_q, sig_x_d;
    logic           done_q, done_q_d;

    logic [R-1:0]   arb_win;
    logic           arb_any;
    logic [PW-1:0]  win_idx;
    logic [R-1:0]   owner_oh;
    logic           done_rise;

`ifdef SIGMOID_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           err_q, err_d;
`endif

    rr_arbiter #(.R(R)) u_rr (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_win),
        .any    (arb_any)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < R; i++) begin
            if (arb_win[i]) win_idx = PW'(i);
        end
    end

    assign owner_oh  = R'(1) << owner_q;
    assign done_rise = sig_done & ~done_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_y_d     = rsp_y_q;
        busy_d      = busy_q;
        clr_n_d     = clr_n_q;
        start_d     = 1'b0;
        sig_x_d     = sig_x_q;
        done_q_d    = sig_done;
`ifdef SIGMOID_ARB_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                clr_n_d = 1'b1;
                busy_d  = arb_any;
                if (arb_any) begin
                    gnt_d   = arb_win;
                    sig_x_d = req_x[int'(win_idx)*W +: W];
                    owner_d = win_idx;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                start_d  = 1'b1;
                clr_n_d  = 1'b0;
                // Edge history is preset high: a done level left over from
                // the previous job must not look like a rising edge. The
                // clear pulse drops done, so the job's own edge follows.
                done_q_d = 1'b1;
`ifdef SIGMOID_ARB_TIMEOUT_EN
                tmo_d    = '0;
`endif
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                clr_n_d = 1'b1;
                if (done_rise) begin
                    rsp_y_d     = sig_y;
                    rsp_valid_d = owner_oh;
                    ptr_d       = owner_q;
                    state_d     = ST_IDLE;
                end
`ifdef SIGMOID_ARB_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    rsp_y_d     = {N{S'(FP_ZERO)}};
                    rsp_valid_d = owner_oh;
                    err_d       = 1'b1;
                    clr_n_d     = 1'b0;
                    ptr_d       = owner_q;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PW'(R - 1);
            owner_q     <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            busy_q      <= 1'b0;
            clr_n_q     <= 1'b0;
            start_q     <= 1'b0;
            sig_x_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            busy_q      <= busy_d;
            clr_n_q     <= clr_n_d;
            start_q     <= start_d;
            sig_x_q     <= sig_x_d;
            done_q      <= done_q_d;
        end
    end

`ifdef SIGMOID_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign busy      = busy_q;
    assign sig_clr_n = clr_n_q;
    assign sig_start = start_q;
    assign sig_x     = sig_x_q;

endmodule
